bisr_remap: RTL and testbench

Built-in self-repair remap stage between the MEMCTRL request path and the SRAM macro. It collects faulty word addresses reported by the BIST engine into a table of spare words held in flops. Each request that hits a logged address is served from the matching spare word. All other requests pass through to the SRAM unchanged. The block also reports repair status (fault count, overflow) back to the BIST/BISR controller.

---
 rtl/bisr_remap.sv | 235 +++++++++++++++++++++++
 tb/tb_bisr_remap.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bisr_remap.sv
// bisr_remap: built-in self-repair remap stage between the memory controller
// and the SRAM macro. BIST-reported faulty word addresses are logged into a
// small table of flop-based spare words. Requests that hit a logged address
// are served from the spare, and all other requests pass through to the SRAM.
module bisr_remap #(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 8,
    parameter int unsigned NSPARE = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          BISR_EN,
    input  logic          FAIL_VALID,
    input  logic [AW-1:0] FAIL_ADDR,
    input  logic          REQ_VALID,
    input  logic          REQ_WE,
    input  logic [AW-1:0] REQ_ADDR,
    input  logic [DW-1:0] REQ_WDATA,
    output logic          MEM_VALID,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    output logic          RVALID,
    output logic [DW-1:0] RDATA,
    output logic [3:0]    FAULT_CNT,
    output logic          REPAIR_FAIL
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        OVF     = 2'd2
    } repair_state_e;

    repair_state_e repair_state_q, repair_state_d;

    // fault table
    logic [NSPARE-1:0] valid_q, valid_d;
    logic [AW-1:0]     addr_q  [NSPARE];
    logic [AW-1:0]     addr_d  [NSPARE];
    logic [DW-1:0]     spare_q [NSPARE];
    logic [DW-1:0]     spare_d [NSPARE];
    logic [CW-1:0]     fault_cnt_q, fault_cnt_d;
    logic              repair_fail_q, repair_fail_d;

    // SRAM-side request registers
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;

    // read return pipeline: stage 1 aligns with MEM_*, stage 2 with MEM_RDATA
    logic              rd1_valid_q, rd1_valid_d;
    logic              rd1_hit_q, rd1_hit_d;
    logic [DW-1:0]     rd1_spare_q, rd1_spare_d;
    logic              rvalid_q, rvalid_d;
    logic              rd2_hit_q, rd2_hit_d;
    logic [DW-1:0]     rd2_spare_q, rd2_spare_d;

    // lookup results
    logic [NSPARE-1:0] req_match;
    logic [NSPARE-1:0] fail_match;
    logic [DW-1:0]     hit_data;
    logic              req_hit;
    logic              fail_dup;
    logic              table_full;
    logic              log_new;
    logic              log_ovf;

    // Associative compare of request and fault addresses against the table
    always_comb begin
        req_match  = '0;
        fail_match = '0;
        hit_data   = '0;
        for (int i = 0; i < int'(NSPARE); i++) begin
            req_match[i]  = valid_q[i] && (addr_q[i] == REQ_ADDR);
            fail_match[i] = valid_q[i] && (addr_q[i] == FAIL_ADDR);
            if (req_match[i]) begin
                hit_data = hit_data | spare_q[i];
            end
        end
    end

    assign req_hit    = BISR_EN && (|req_match);
    assign fail_dup   = |fail_match;
    assign table_full = (fault_cnt_q >= CW'(NSPARE));
    assign log_new    = FAIL_VALID && !fail_dup && !table_full;
    assign log_ovf    = FAIL_VALID && !fail_dup && table_full;

    // Table update: spare write on a write hit, new entry on a fresh fault
    always_comb begin
        valid_d     = valid_q;
        addr_d      = addr_q;
        spare_d     = spare_q;
        fault_cnt_d = fault_cnt_q;
        if (REQ_VALID && REQ_WE && req_hit) begin
            for (int i = 0; i < int'(NSPARE); i++) begin
                if (req_match[i]) begin
                    spare_d[i] = REQ_WDATA;
                end
            end
        end
        // the slot being filled is always invalid, so it never collides with a hit
        if (log_new) begin
            for (int i = 0; i < int'(NSPARE); i++) begin
                if (CW'(i) == fault_cnt_q) begin
                    valid_d[i] = 1'b1;
                    addr_d[i]  = FAIL_ADDR;
                    spare_d[i] = '0;
                end
            end
            fault_cnt_d = fault_cnt_q + CW'(1);
        end
    end

    // Repair state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            repair_state_q <= COLLECT;
        end else begin
            repair_state_q <= repair_state_d;
        end
    end

    // Repair state next-state logic
    always_comb begin
        repair_state_d = repair_state_q;
        case (repair_state_q)
            COLLECT: begin
                if (fault_cnt_d == CW'(NSPARE)) begin
                    repair_state_d = FULL;
                end
            end
            FULL: begin
                if (log_ovf) begin
                    repair_state_d = OVF;
                end
            end
            OVF: begin
                repair_state_d = OVF;
            end
            default: begin
                repair_state_d = COLLECT;
            end
        endcase
    end

    // Repair state output decode, registered with the state
    always_comb begin
        repair_fail_d = 1'b0;
        if (repair_state_d == OVF) begin
            repair_fail_d = 1'b1;
        end
    end

    // Request forwarding and read pipeline next values
    always_comb begin
        mem_valid_d = REQ_VALID && !req_hit;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (REQ_VALID && !req_hit) begin
            mem_we_d    = REQ_WE;
            mem_addr_d  = REQ_ADDR;
            mem_wdata_d = REQ_WDATA;
        end

        rd1_valid_d = REQ_VALID && !REQ_WE;
        rd1_hit_d   = req_hit;
        rd1_spare_d = rd1_spare_q;
        if (REQ_VALID && !REQ_WE && req_hit) begin
            rd1_spare_d = hit_data;
        end

        rvalid_d    = rd1_valid_q;
        rd2_hit_d   = rd1_hit_q;
        rd2_spare_d = rd1_spare_q;
    end

    // Table, status and pipeline registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q       <= '0;
            for (int i = 0; i < int'(NSPARE); i++) begin
                addr_q[i]  <= '0;
                spare_q[i] <= '0;
            end
            fault_cnt_q   <= '0;
            repair_fail_q <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rd1_valid_q   <= 1'b0;
            rd1_hit_q     <= 1'b0;
            rd1_spare_q   <= '0;
            rvalid_q      <= 1'b0;
            rd2_hit_q     <= 1'b0;
            rd2_spare_q   <= '0;
        end else begin
            valid_q       <= valid_d;
            for (int i = 0; i < int'(NSPARE); i++) begin
                addr_q[i]  <= addr_d[i];
                spare_q[i] <= spare_d[i];
            end
            fault_cnt_q   <= fault_cnt_d;
            repair_fail_q <= repair_fail_d;
            mem_valid_q   <= mem_valid_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rd1_valid_q   <= rd1_valid_d;
            rd1_hit_q     <= rd1_hit_d;
            rd1_spare_q   <= rd1_spare_d;
            rvalid_q      <= rvalid_d;
            rd2_hit_q     <= rd2_hit_d;
            rd2_spare_q   <= rd2_spare_d;
        end
    end

    assign MEM_VALID   = mem_valid_q;
    assign MEM_WE      = mem_we_q;
    assign MEM_ADDR    = mem_addr_q;
    assign MEM_WDATA   = mem_wdata_q;
    assign RVALID      = rvalid_q;
    assign FAULT_CNT   = fault_cnt_q;
    assign REPAIR_FAIL = repair_fail_q;

    // SRAM data arrives in the RVALID cycle, so the return mux stays after the flops
    assign RDATA = rvalid_q ? (rd2_hit_q ? rd2_spare_q : MEM_RDATA) : '0;

endmodule

// File: tb/tb_bisr_remap.sv
// Testbench for bisr_remap: directed stimulus, a behavioural repair model
// compared every cycle, and literal spot checks.
module tb_bisr_remap;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          BISR_EN = 1'b1;
    logic          FAIL_VALID = 1'b0;
    logic [AW-1:0] FAIL_ADDR = '0;
    logic          REQ_VALID = 1'b0;
    logic          REQ_WE = 1'b0;
    logic [AW-1:0] REQ_ADDR = '0;
    logic [DW-1:0] REQ_WDATA = '0;
    logic          MEM_VALID;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA = '0;
    logic          RVALID;
    logic [DW-1:0] RDATA;
    logic [3:0]    FAULT_CNT;
    logic          REPAIR_FAIL;

    int n_tests = 0;
    int n_fail  = 0;
    logic en_g = 1'b1;

    bisr_remap #(.AW(AW), .DW(DW), .NSPARE(8)) dut (
        .CLK(CLK), .RST(RST), .BISR_EN(BISR_EN),
        .FAIL_VALID(FAIL_VALID), .FAIL_ADDR(FAIL_ADDR),
        .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .MEM_VALID(MEM_VALID), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .RVALID(RVALID), .RDATA(RDATA),
        .FAULT_CNT(FAULT_CNT), .REPAIR_FAIL(REPAIR_FAIL)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // external SRAM: one-cycle read latency, contents survive DUT reset
    logic [7:0] b_sram [int];
    always @(posedge CLK) begin
        if (MEM_VALID) begin
            if (MEM_WE) b_sram[int'(MEM_ADDR)] = MEM_WDATA;
            else MEM_RDATA = b_sram.exists(int'(MEM_ADDR)) ? b_sram[int'(MEM_ADDR)] : dflt(MEM_ADDR);
        end
    end

    // behavioural model of the remap: expected outputs after each edge
    logic [15:0] m_addr  [8];
    logic [7:0]  m_spare [8];
    logic [7:0]  m_sram  [int];
    int   m_n = 0;
    bit   m_ovf = 0;
    bit   m_ok = 0;
    bit   e_mv = 0, e_we = 0, e_rv = 0;
    logic [15:0] e_a = '0;
    logic [7:0]  e_wd = '0, e_rd = '0;
    bit   s1_v = 0;
    logic [7:0]  s1_d = '0;

    always @(posedge CLK) begin
        bit hit, dup;
        int idx;
        if (RST) begin
            m_n = 0; m_ovf = 0; e_mv = 0; e_rv = 0; s1_v = 0; m_ok = 1;
        end else begin
            e_rv = s1_v;
            e_rd = s1_d;
            hit = 0; idx = 0;
            if (BISR_EN)
                for (int i = 0; i < m_n; i++)
                    if (m_addr[i] == REQ_ADDR) begin hit = 1; idx = i; end
            e_mv = 0;
            s1_v = 0;
            if (REQ_VALID) begin
                if (!hit) begin
                    e_mv = 1; e_we = REQ_WE; e_a = REQ_ADDR; e_wd = REQ_WDATA;
                    if (REQ_WE) m_sram[int'(REQ_ADDR)] = REQ_WDATA;
                    else begin
                        s1_v = 1;
                        s1_d = m_sram.exists(int'(REQ_ADDR)) ? m_sram[int'(REQ_ADDR)] : dflt(REQ_ADDR);
                    end
                end else if (REQ_WE) begin
                    m_spare[idx] = REQ_WDATA;
                end else begin
                    s1_v = 1;
                    s1_d = m_spare[idx];
                end
            end
            if (FAIL_VALID) begin
                dup = 0;
                for (int i = 0; i < m_n; i++)
                    if (m_addr[i] == FAIL_ADDR) dup = 1;
                if (!dup) begin
                    if (m_n < 8) begin
                        m_addr[m_n] = FAIL_ADDR; m_spare[m_n] = 8'h00; m_n++;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
        end
    end

    // per-cycle compare against the model
    always @(negedge CLK) begin
        if (m_ok) begin
            check("mem_valid", 32'(MEM_VALID), 32'(e_mv));
            if (e_mv) begin
                check("mem_we", 32'(MEM_WE), 32'(e_we));
                check("mem_addr", 32'(MEM_ADDR), 32'(e_a));
                check("mem_wdata", 32'(MEM_WDATA), 32'(e_wd));
            end
            check("rvalid", 32'(RVALID), 32'(e_rv));
            if (e_rv) check("rdata", 32'(RDATA), 32'(e_rd));
            check("fault_cnt", 32'(FAULT_CNT), 32'(m_n));
            check("repair_fail", 32'(REPAIR_FAIL), 32'(m_ovf));
        end
    end

    task automatic drive(input logic rst, input logic fv, input logic [15:0] fa,
                         input logic rv, input logic we, input logic [15:0] ra, input logic [7:0] wd);
        @(negedge CLK);
        RST = rst; BISR_EN = en_g;
        FAIL_VALID = fv; FAIL_ADDR = fa;
        REQ_VALID = rv; REQ_WE = we; REQ_ADDR = ra; REQ_WDATA = wd;
    endtask

    task automatic idle();                             drive(0, 0, 16'h0, 0, 0, 16'h0, 8'h0); endtask
    task automatic do_rst();                           drive(1, 0, 16'h0, 0, 0, 16'h0, 8'h0); endtask
    task automatic wr(input logic [15:0] a, input logic [7:0] d); drive(0, 0, 16'h0, 1, 1, a, d); endtask
    task automatic rd(input logic [15:0] a);           drive(0, 0, 16'h0, 1, 0, a, 8'h0); endtask
    task automatic flt(input logic [15:0] a);          drive(0, 1, a, 0, 0, 16'h0, 8'h0); endtask

    initial begin
        // reset values
        do_rst();
        idle();
        check("rst_mem_valid", 32'(MEM_VALID), 32'd0);
        check("rst_mem_we", 32'(MEM_WE), 32'd0);
        check("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        check("rst_mem_wdata", 32'(MEM_WDATA), 32'd0);
        check("rst_rvalid", 32'(RVALID), 32'd0);
        check("rst_rdata", 32'(RDATA), 32'd0);
        check("rst_fault_cnt", 32'(FAULT_CNT), 32'd0);
        check("rst_repair_fail", 32'(REPAIR_FAIL), 32'd0);

        // pass-through with no faults
        wr(16'h1234, 8'h3C);
        rd(16'h1234);
        idle();
        check("pt_rd_mem_valid", 32'(MEM_VALID), 32'd1);
        check("pt_rd_mem_addr", 32'(MEM_ADDR), 32'h1234);
        check("pt_rd_mem_we", 32'(MEM_WE), 32'd0);
        idle();
        check("pt_rvalid", 32'(RVALID), 32'd1);
        check("pt_rdata", 32'(RDATA), 32'h3C);
        rd(16'h0007);
        idle(); idle();
        check("pt_rdata_dflt", 32'(RDATA), 32'h5D);
        for (int i = 0; i < 100; i++) wr(16'(i * 37), 8'($urandom));
        for (int i = 0; i < 100; i++) rd(16'(i * 37));
        idle(); idle(); idle();
        check("pt_fault_cnt", 32'(FAULT_CNT), 32'd0);

        // basic remap
        do_rst();
        flt(16'h0003); flt(16'h0010); flt(16'h0003);
        idle();
        check("dup_fault_cnt", 32'(FAULT_CNT), 32'd2);
        wr(16'h0003, 8'hA5);
        idle();
        check("hit_wr_mem_valid", 32'(MEM_VALID), 32'd0);
        rd(16'h0003);
        idle();
        check("hit_rd_mem_valid", 32'(MEM_VALID), 32'd0);
        idle();
        check("hit_rvalid", 32'(RVALID), 32'd1);
        check("hit_rdata", 32'(RDATA), 32'hA5);
        rd(16'h0004);
        idle();
        check("miss_mem_valid", 32'(MEM_VALID), 32'd1);
        check("miss_mem_addr", 32'(MEM_ADDR), 32'h0004);
        idle();
        check("miss_rdata", 32'(RDATA), 32'h5E);

        // table fill and overflow
        do_rst();
        for (int i = 0; i < 8; i++) flt(16'(16'h0100 + i));
        idle();
        check("full_cnt", 32'(FAULT_CNT), 32'd8);
        check("full_rf", 32'(REPAIR_FAIL), 32'd0);
        flt(16'h0100);
        idle();
        check("full_dup_rf", 32'(REPAIR_FAIL), 32'd0);
        flt(16'h0108);
        idle();
        check("ovf_rf", 32'(REPAIR_FAIL), 32'd1);
        check("ovf_cnt", 32'(FAULT_CNT), 32'd8);
        flt(16'h0101); flt(16'h0200);
        rd(16'h0108);
        idle();
        check("ovf_unlogged_miss", 32'(MEM_VALID), 32'd1);
        check("ovf_sticky", 32'(REPAIR_FAIL), 32'd1);
        idle();

        // BISR_EN toggling
        do_rst();
        flt(16'h0020);
        wr(16'h0020, 8'h77);
        en_g = 1'b0;
        rd(16'h0020);
        idle();
        check("dis_mem_valid", 32'(MEM_VALID), 32'd1);
        check("dis_mem_addr", 32'(MEM_ADDR), 32'h0020);
        idle();
        check("dis_rdata", 32'(RDATA), 32'h7A);
        wr(16'h0020, 8'h99);
        en_g = 1'b1;
        rd(16'h0020);
        idle();
        check("en_mem_valid", 32'(MEM_VALID), 32'd0);
        idle();
        check("en_rdata", 32'(RDATA), 32'h77);
        rd(16'h0020); rd(16'h0021); rd(16'h0020); rd(16'h0022);
        idle(); idle(); idle();

        // same-cycle fault and request
        do_rst();
        drive(0, 1, 16'h0040, 1, 1, 16'h0040, 8'h11);
        wr(16'h0040, 8'h22);
        check("same_cyc_mem_valid", 32'(MEM_VALID), 32'd1);
        check("same_cyc_mem_we", 32'(MEM_WE), 32'd1);
        check("same_cyc_mem_wdata", 32'(MEM_WDATA), 32'h11);
        rd(16'h0040);
        check("next_cyc_mem_valid", 32'(MEM_VALID), 32'd0);
        idle();
        check("raw_rd_mem_valid", 32'(MEM_VALID), 32'd0);
        idle();
        check("raw_rvalid", 32'(RVALID), 32'd1);
        check("raw_rdata", 32'(RDATA), 32'h22);

        // reset with a read hit in flight
        rd(16'h0040);
        do_rst();
        idle();
        check("mid_rst_rvalid", 32'(RVALID), 32'd0);
        check("mid_rst_rdata", 32'(RDATA), 32'd0);
        check("mid_rst_mem_valid", 32'(MEM_VALID), 32'd0);
        check("mid_rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        check("mid_rst_cnt", 32'(FAULT_CNT), 32'd0);
        idle();
        check("mid_rst_rvalid2", 32'(RVALID), 32'd0);
        rd(16'h0040);
        idle();
        check("post_rst_mem_valid", 32'(MEM_VALID), 32'd1);
        check("post_rst_mem_addr", 32'(MEM_ADDR), 32'h0040);
        idle();
        check("post_rst_rdata", 32'(RDATA), 32'h11);
        idle(); idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
